rotor_stepper: RTL and testbench

ROTOR_STEPPER -- requirements
Module: rotor_stepper

---
 rtl/enigma_pkg.sv | 26 ++
 rtl/rotor_notch_lookup.sv | 18 +
 rtl/rotor_stepper.sv | 124 ++++++++++++
 tb/tb_rotor_stepper.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/enigma_pkg.sv
// Shared Enigma constants: alphabet size, rotor type codes, notch table and
// the stepping controller state encoding.
package enigma_pkg;

  localparam int ALPHABET = 26;

  localparam logic [2:0] ROTOR_I    = 3'd0;
  localparam logic [2:0] ROTOR_II   = 3'd1;
  localparam logic [2:0] ROTOR_III  = 3'd2;
  localparam logic [2:0] ROTOR_IV   = 3'd3;
  localparam logic [2:0] ROTOR_V    = 3'd4;
  localparam logic [2:0] ROTOR_VI   = 3'd5;
  localparam logic [2:0] ROTOR_VII  = 3'd6;
  localparam logic [2:0] ROTOR_VIII = 3'd7;

  // Single-notch rotors repeat their notch in both tables so the lookup is uniform.
  localparam logic [4:0] NOTCH_A [8] = '{5'd16, 5'd4, 5'd21, 5'd9, 5'd25, 5'd12, 5'd12, 5'd12};
  localparam logic [4:0] NOTCH_B [8] = '{5'd16, 5'd4, 5'd21, 5'd9, 5'd25, 5'd25, 5'd25, 5'd25};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EVAL    = 2'd1,
    ST_ADVANCE = 2'd2
  } step_state_t;

endpackage

// File: rtl/rotor_notch_lookup.sv
// Combinational notch detector: high when a rotor of the given type sits at
// one of its turnover notches.
module rotor_notch_lookup
  import enigma_pkg::*;
#(
  parameter int POS_W = 5
) (
  input  logic [2:0]       rtype_i,
  input  logic [POS_W-1:0] pos_i,
  output logic             notch_o
);

  always_comb begin
    notch_o = (pos_i == POS_W'(NOTCH_A[rtype_i])) ||
              (pos_i == POS_W'(NOTCH_B[rtype_i]));
  end

endmodule

// File: rtl/rotor_stepper.sv
// Enigma rotor stepping controller: one keypress evaluates notches, then
// advances the rotors simultaneously, including the middle-rotor double step.
module rotor_stepper
  import enigma_pkg::*;
#(
  parameter int NUM_ROTORS   = 3,
  parameter int NUM_STEPPING = 3,
  parameter int DOUBLE_STEP  = 1,
  parameter int POS_W        = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        step_req,
  output logic                        busy,
  output logic                        step_done,
  input  logic                        load_en,
  input  logic [1:0]                  load_idx,
  input  logic [POS_W-1:0]            load_pos,
  input  logic [3*NUM_ROTORS-1:0]     rotor_types,
  output logic [NUM_ROTORS-1:0]       stepped,
  output logic [POS_W*NUM_ROTORS-1:0] positions,
  output step_state_t                 dbg_state_o
);

  // Handshake: step_req is a single-cycle request taken only while busy is low;
  // step_done pulses one cycle when the new positions become visible.

  step_state_t            state_q;
  logic                   busy_q;
  logic                   done_q;
  logic [NUM_ROTORS-1:0]  stepped_q;
  logic [NUM_ROTORS-1:0]  notch_q;
  logic [NUM_ROTORS-1:0]  notch_d;
  logic [NUM_ROTORS-1:0]  step_vec;
  logic [POS_W-1:0]       pos_q [NUM_ROTORS];
  logic                   load_hit;
  logic [POS_W-1:0]       load_val;

  for (genvar g = 0; g < NUM_ROTORS; g++) begin : g_notch
    rotor_notch_lookup #(.POS_W(POS_W)) u_lookup (
      .rtype_i (rotor_types[3*g +: 3]),
      .pos_i   (pos_q[g]),
      .notch_o (notch_d[g])
    );
  end

  // Decisions use only the notch flags captured in EVAL, so every slot moves as one.
  always_comb begin
    step_vec    = '0;
    step_vec[0] = 1'b1;
    for (int i = 1; i < NUM_STEPPING; i++) begin
      step_vec[i] = notch_q[i-1];
      if (DOUBLE_STEP != 0 && i < NUM_STEPPING - 1) begin
        step_vec[i] = step_vec[i] | notch_q[i];
      end
    end
  end

  always_comb begin
    load_hit = load_en && (32'(load_idx) < NUM_ROTORS);
    load_val = (load_pos >= POS_W'(ALPHABET)) ? '0 : load_pos;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      stepped_q <= '0;
      notch_q   <= '0;
      for (int i = 0; i < NUM_ROTORS; i++) begin
        pos_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (step_req) begin
            state_q <= ST_EVAL;
            busy_q  <= 1'b1;
          end else if (load_hit) begin
            for (int i = 0; i < NUM_ROTORS; i++) begin
              if (32'(load_idx) == i) begin
                pos_q[i] <= load_val;
              end
            end
          end
        end
        ST_EVAL: begin
          notch_q <= notch_d;
          state_q <= ST_ADVANCE;
        end
        ST_ADVANCE: begin
          for (int i = 0; i < NUM_ROTORS; i++) begin
            if (step_vec[i]) begin
              pos_q[i] <= (pos_q[i] == POS_W'(ALPHABET - 1)) ? '0 : pos_q[i] + POS_W'(1);
            end
          end
          stepped_q <= step_vec;
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    positions = '0;
    for (int i = 0; i < NUM_ROTORS; i++) begin
      positions[i*POS_W +: POS_W] = pos_q[i];
    end
  end

  assign busy        = busy_q;
  assign step_done   = done_q;
  assign stepped     = stepped_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_rotor_stepper.sv
// Directed bench for rotor_stepper: a 3-slot default instance and a 4-slot
// instance with one fixed rotor, checked against hand-computed positions.
module tb_rotor_stepper;
  import enigma_pkg::*;

  logic clk;
  logic reset;

  logic        step_req3, load_en3, busy3, done3;
  logic [1:0]  load_idx3;
  logic [4:0]  load_pos3;
  logic [8:0]  rt3;
  logic [2:0]  stp3;
  logic [14:0] pos3;
  step_state_t st3;

  logic        step_req4, load_en4, busy4, done4;
  logic [1:0]  load_idx4;
  logic [4:0]  load_pos4;
  logic [11:0] rt4;
  logic [3:0]  stp4;
  logic [19:0] pos4;
  step_state_t st4;

  int vectors;
  int miscompares;

  rotor_stepper dut3 (
    .clk         (clk),
    .reset       (reset),
    .step_req    (step_req3),
    .busy        (busy3),
    .step_done   (done3),
    .load_en     (load_en3),
    .load_idx    (load_idx3),
    .load_pos    (load_pos3),
    .rotor_types (rt3),
    .stepped     (stp3),
    .positions   (pos3),
    .dbg_state_o (st3)
  );

  rotor_stepper #(.NUM_ROTORS(4), .NUM_STEPPING(3)) dut4 (
    .clk         (clk),
    .reset       (reset),
    .step_req    (step_req4),
    .busy        (busy4),
    .step_done   (done4),
    .load_en     (load_en4),
    .load_idx    (load_idx4),
    .load_pos    (load_pos4),
    .rotor_types (rt4),
    .stepped     (stp4),
    .positions   (pos4),
    .dbg_state_o (st4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] p3(input int s0, input int s1, input int s2);
    return {5'(s2), 5'(s1), 5'(s0)};
  endfunction

  function automatic logic [19:0] p4(input int s0, input int s1, input int s2, input int s3);
    return {5'(s3), 5'(s2), 5'(s1), 5'(s0)};
  endfunction

  task automatic load3(input int idx, input int val);
    load_en3  = 1'b1;
    load_idx3 = 2'(idx);
    load_pos3 = 5'(val);
    tick();
    load_en3  = 1'b0;
  endtask

  task automatic step3(input string tag);
    step_req3 = 1'b1;
    tick();
    step_req3 = 1'b0;
    check({tag, "_busy_eval"}, 32'(busy3), 32'd1);
    check({tag, "_state_eval"}, 32'(st3), 32'(ST_EVAL));
    tick();
    check({tag, "_done_early"}, 32'(done3), 32'd0);
    tick();
    check({tag, "_done"}, 32'(done3), 32'd1);
    check({tag, "_busy_idle"}, 32'(busy3), 32'd0);
  endtask

  task automatic step4();
    step_req4 = 1'b1;
    tick();
    step_req4 = 1'b0;
    tick();
    tick();
    check("r4_done", 32'(done4), 32'd1);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    step_req3 = 1'b0; load_en3 = 1'b0; load_idx3 = '0; load_pos3 = '0;
    step_req4 = 1'b0; load_en4 = 1'b0; load_idx4 = '0; load_pos4 = '0;
    rt3 = {ROTOR_III, ROTOR_II, ROTOR_I};
    rt4 = {ROTOR_IV, ROTOR_III, ROTOR_II, ROTOR_I};
    tick();
    tick();
    reset = 1'b0;

    check("rst_pos", 32'(pos3), 32'd0);
    check("rst_stepped", 32'(stp3), 32'd0);
    check("rst_busy", 32'(busy3), 32'd0);
    check("rst_done", 32'(done3), 32'd0);
    check("rst_state", 32'(st3), 32'(ST_IDLE));
    check("rst_pos4", 32'(pos4), 32'd0);

    // First keypress from 0/0/0: only the fast rotor moves.
    step3("s1");
    check("s1_pos", 32'(pos3), 32'(p3(1, 0, 0)));
    check("s1_stepped", 32'(stp3), 32'b001);
    tick();
    check("s1_done_drop", 32'(done3), 32'd0);

    // Double step: III at its notch, II one short of its notch.
    rt3 = {ROTOR_I, ROTOR_II, ROTOR_III};
    load3(0, 21);
    load3(1, 3);
    load3(2, 0);
    check("ds_load", 32'(pos3), 32'(p3(21, 3, 0)));
    step3("ds1");
    check("ds1_pos", 32'(pos3), 32'(p3(22, 4, 0)));
    check("ds1_stepped", 32'(stp3), 32'b011);
    step3("ds2");
    check("ds2_pos", 32'(pos3), 32'(p3(23, 5, 1)));
    check("ds2_stepped", 32'(stp3), 32'b111);

    // Wrap and dual notch with rotor VI in slot 0.
    rt3 = {ROTOR_I, ROTOR_II, ROTOR_VI};
    load3(0, 25);
    load3(1, 0);
    load3(2, 0);
    step3("w1");
    check("w1_pos", 32'(pos3), 32'(p3(0, 1, 0)));
    check("w1_stepped", 32'(stp3), 32'b011);
    load3(0, 12);
    step3("w2");
    check("w2_pos", 32'(pos3), 32'(p3(13, 2, 0)));
    check("w2_stepped", 32'(stp3), 32'b011);
    step3("w3");
    check("w3_pos", 32'(pos3), 32'(p3(14, 2, 0)));
    check("w3_stepped", 32'(stp3), 32'b001);

    // Holding step_req across the busy window yields a single advance.
    step_req3 = 1'b1;
    tick();
    tick();
    tick();
    step_req3 = 1'b0;
    check("busy_ign_done", 32'(done3), 32'd1);
    check("busy_ign_pos", 32'(pos3), 32'(p3(15, 2, 0)));
    tick();
    tick();
    tick();
    check("busy_ign_pos_after", 32'(pos3), 32'(p3(15, 2, 0)));
    check("busy_ign_busy", 32'(busy3), 32'd0);

    load3(1, 5);
    check("load5", 32'(pos3), 32'(p3(15, 5, 0)));
    load3(1, 30);
    check("load30", 32'(pos3), 32'(p3(15, 0, 0)));
    load3(3, 9);
    check("load_idx3", 32'(pos3), 32'(p3(15, 0, 0)));

    // Load and step together: the load is dropped.
    step_req3 = 1'b1;
    load_en3  = 1'b1;
    load_idx3 = 2'd0;
    load_pos3 = 5'd3;
    tick();
    step_req3 = 1'b0;
    load_en3  = 1'b0;
    tick();
    tick();
    check("sim_done", 32'(done3), 32'd1);
    check("sim_pos", 32'(pos3), 32'(p3(16, 0, 0)));

    // Rotor type change during ADVANCE must not alter the step in flight.
    rt3 = {ROTOR_I, ROTOR_II, ROTOR_I};
    load3(0, 16);
    step_req3 = 1'b1;
    tick();
    step_req3 = 1'b0;
    tick();
    rt3 = {ROTOR_I, ROTOR_II, ROTOR_II};
    tick();
    check("type_chg_pos", 32'(pos3), 32'(p3(17, 1, 0)));
    check("type_chg_stepped", 32'(stp3), 32'b011);

    // Reset landing on the ADVANCE edge, with load and step also asserted.
    step_req3 = 1'b1;
    tick();
    step_req3 = 1'b0;
    tick();
    check("mid_state", 32'(st3), 32'(ST_ADVANCE));
    reset     = 1'b1;
    step_req3 = 1'b1;
    load_en3  = 1'b1;
    load_idx3 = 2'd1;
    load_pos3 = 5'd5;
    tick();
    reset     = 1'b0;
    step_req3 = 1'b0;
    load_en3  = 1'b0;
    check("mid_rst_pos", 32'(pos3), 32'd0);
    check("mid_rst_done", 32'(done3), 32'd0);
    check("mid_rst_busy", 32'(busy3), 32'd0);
    check("mid_rst_stepped", 32'(stp3), 32'd0);
    check("mid_rst_state", 32'(st3), 32'(ST_IDLE));
    tick();
    check("mid_rst_done2", 32'(done3), 32'd0);
    check("mid_rst_pos2", 32'(pos3), 32'd0);

    // Four slots, three stepping: slot 3 is fixed at 7.
    load_en4  = 1'b1;
    load_idx4 = 2'd3;
    load_pos4 = 5'd7;
    tick();
    load_en4  = 1'b0;
    check("r4_load", 32'(pos4), 32'(p4(0, 0, 0, 7)));
    for (int k = 0; k < 100; k++) begin
      step4();
      check("r4_stepped3", 32'(stp4[3]), 32'd0);
      check("r4_slot3", 32'(pos4[19:15]), 32'd7);
    end
    check("r4_final", 32'(pos4), 32'(p4(22, 5, 1, 7)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
